// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the MSB-at-index-0 word type.
package sha256_pkg;

  localparam int unsigned WORD_W = 32;

  localparam int unsigned S0_R1 = 7;
  localparam int unsigned S0_R2 = 18;
  localparam int unsigned S0_SH = 3;

  typedef logic [0:WORD_W-1] word_t;

endpackage

// File: rtl/sha256_rotr.sv
// Constant rotate-right on the numeric value of a word.
// Index 0 is the MSB, so the low-order bits are taken from the high end of the index range.
module sha256_rotr
  import sha256_pkg::*;
#(
  parameter int unsigned SHIFT = 1
) (
  input  word_t word_i,
  output word_t word_o
);

  // Valid for 1 <= SHIFT <= WORD_W-1. The low-order bits move up to the MSB end.
  assign word_o = {word_i[WORD_W-SHIFT:WORD_W-1], word_i[0:WORD_W-SHIFT-1]};

endmodule

// File: rtl/sha256_sigma0.sv
// SHA-256 small sigma-0 for the message schedule.
// Gives a zero-latency result and a registered copy with a valid flag.
module sha256_sigma0
  import sha256_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:31]   A,
  input  logic          in_valid,
  output logic [0:31]   Y,
  output logic [0:31]   Y_q,
  output logic          out_valid
);

  word_t rot1;
  word_t rot2;
  word_t shr;
  word_t res_d, res_q;
  logic  vld_d, vld_q;

  sha256_rotr #(.SHIFT(S0_R1)) u_rotr_r1 (
    .word_i (A),
    .word_o (rot1)
  );

  sha256_rotr #(.SHIFT(S0_R2)) u_rotr_r2 (
    .word_i (A),
    .word_o (rot2)
  );

  assign shr = {{S0_SH{1'b0}}, A[0:WORD_W-S0_SH-1]};
  assign Y   = rot1 ^ rot2 ^ shr;

  // The result register holds across idle cycles; only the flag clears.
  always_comb begin
    res_d = res_q;
    vld_d = 1'b0;
    if (in_valid) begin
      res_d = Y;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end

  assign Y_q       = res_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_sha256_sigma0.sv
// Self-checking bench for sha256_sigma0: directed vectors, streaming, reset, hold and random traffic.
module tb_sha256_sigma0;

  logic        clk;
  logic        rst_n;
  logic [0:31] A;
  logic        in_valid;
  logic [0:31] Y;
  logic [0:31] Y_q;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_yq;
  logic        exp_ov;

  sha256_sigma0 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .in_valid  (in_valid),
    .Y         (Y),
    .Y_q       (Y_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: numeric rotations and shift on a plain 32-bit value.
  function automatic logic [31:0] ref_sigma0(input logic [31:0] x);
    logic [31:0] r7, r18, s3;
    r7  = (x >> 7)  | (x << 25);
    r18 = (x >> 18) | (x << 14);
    s3  = x >> 3;
    return r7 ^ r18 ^ s3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check the combinational output, then the registered outputs after the edge.
  task automatic cycle(input logic [31:0] a, input logic v, input string tag);
    @(negedge clk);
    A        = a;
    in_valid = v;
    #1;
    check({tag, "_y"}, Y, ref_sigma0(a));
    @(posedge clk);
    if (rst_n) begin
      if (v) begin
        exp_yq = ref_sigma0(a);
        exp_ov = 1'b1;
      end else begin
        exp_ov = 1'b0;
      end
    end
    #1;
    check({tag, "_yq"}, Y_q, exp_yq);
    check({tag, "_ov"}, {31'd0, out_valid}, {31'd0, exp_ov});
  endtask

  logic [31:0] vecs [4];
  logic [31:0] vexp [4];
  logic [31:0] ra;
  logic        rv;

  initial begin
    vecs[0] = 32'hFFFF_0000; vexp[0] = 32'hDE00_21FF;
    vecs[1] = 32'hF0F0_F0F0; vexp[1] = 32'hC3C3_C3C3;
    vecs[2] = 32'hCCCC_CCCC; vexp[2] = 32'hB333_3333;
    vecs[3] = 32'hAAAA_AAAA; vexp[3] = 32'hEAAA_AAAA;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 32'hFFFF_FFFF;
    exp_yq   = 32'h0;
    exp_ov   = 1'b0;
    #2;
    check("rst_yq", Y_q, 32'h0);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("allones_y", Y, 32'h1FFF_FFFF);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed spec constants on the combinational path.
    for (int i = 0; i < 4; i++) begin
      A = vecs[i];
      #1;
      check("const_y", Y, vexp[i]);
    end

    // Single capture, then back-to-back streaming of the four vectors.
    cycle(32'hFFFF_0000, 1'b1, "single");
    check("single_const_yq", Y_q, 32'hDE00_21FF);
    for (int i = 0; i < 4; i++) begin
      cycle(vecs[i], 1'b1, "stream");
      check("stream_const_yq", Y_q, vexp[i]);
    end

    // Idle cycles: result holds, flag drops.
    cycle(32'h1234_5678, 1'b0, "hold1");
    cycle(32'h9ABC_DEF0, 1'b0, "hold2");
    check("hold_const_yq", Y_q, 32'hEAAA_AAAA);

    // Reset pulse mid-stream, away from any edge.
    cycle(32'hDEAD_BEEF, 1'b1, "pre_rst");
    @(negedge clk);
    A        = 32'h0BAD_F00D;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_yq", Y_q, 32'h0);
    check("midrst_ov", {31'd0, out_valid}, 32'd0);
    exp_yq = 32'h0;
    exp_ov = 1'b0;
    cycle(32'h0BAD_F00D, 1'b1, "inrst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(32'hCAFE_BABE, 1'b1, "post_rst");

    // Random traffic against the reference.
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rv = 1'($urandom_range(0, 1));
      cycle(ra, rv, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
